// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Main control FSM for the multicycle RV32I core. Decodes the instruction
// register fields and sequences the shared datapath (PC, unified memory,
// register file, single ALU). Each instruction takes 3 to 5 cycles.
//
// Ports:
//   clk         in   single clock, all state on rising edge
//   reset       in   synchronous, active-high
//   op          in   instr[6:0]
//   funct3      in   instr[14:12]
//   funct7b5    in   instr[30]
//   Zero        in   ALU result == 0
//   lt          in   ALU signed SrcA < SrcB
//   ltu         in   ALU unsigned SrcA < SrcB
//   PCWrite     out  load PC from Result
//   AdrSrc      out  memory address select: 0 = PC, 1 = Result
//   MemWrite    out  memory write strobe
//   IRWrite     out  load IR and OldPC
//   RegWrite    out  register file write strobe
//   ResultSrc   out  00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA     out  00 = PC, 01 = OldPC, 10 = rd1, 11 = zero
//   ALUSrcB     out  00 = rd2, 01 = ImmExt, 10 = constant 4
//   ImmSrc      out  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
//   ALUControl  out  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT, 110 SLTU
//   Illegal     out  one-cycle pulse in DECODE for an unsupported op

module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       lt,
   input  logic       ltu,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   // Opcodes
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   // ALU operation codes
   localparam logic [2:0] AluAdd  = 3'b000;
   localparam logic [2:0] AluSub  = 3'b001;
   localparam logic [2:0] AluAnd  = 3'b010;
   localparam logic [2:0] AluOr   = 3'b011;
   localparam logic [2:0] AluSlt  = 3'b101;
   localparam logic [2:0] AluSltu = 3'b110;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StJalrAdr  = 4'd9,
      StJal      = 4'd10,
      StLui      = 4'd11,
      StAuipc    = 4'd12,
      StBranch   = 4'd13
   } state_t;

   state_t     state_q, state_d;
   state_t     out_state;
   logic [1:0] alu_op;
   logic       op_legal;
   logic       taken;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Opcode legality, shared by next-state and Illegal
   always_comb begin
      unique case (op)
         OpLoad, OpStore, OpRType, OpIType, OpBranch,
         OpJal, OpJalr, OpLui, OpAuipc: op_legal = 1'b1;
         default:                       op_legal = 1'b0;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            unique case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecR;
               OpIType:         state_d = StExecI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalrAdr;
               OpLui:           state_d = StLui;
               OpAuipc:         state_d = StAuipc;
               default:         state_d = StFetch;
            endcase
         end
         StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
         StMemRead:  state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = StFetch;
         StExecR:    state_d = StAluWb;
         StExecI:    state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StJalrAdr:  state_d = StJal;
         StJal:      state_d = StAluWb;
         StLui:      state_d = StAluWb;
         StAuipc:    state_d = StAluWb;
         StBranch:   state_d = StFetch;
         default:    state_d = StFetch;
      endcase
   end

   // Branch condition from the ALU compare flags
   always_comb begin
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = ~Zero;
         3'b100:  taken = lt;
         3'b101:  taken = ~lt;
         3'b110:  taken = ltu;
         3'b111:  taken = ~ltu;
         default: taken = 1'b0;
      endcase
   end

   // Moore outputs. While reset is high the outputs show FETCH selects with
   // every write strobe masked, whatever state the register still holds.
   always_comb begin
      out_state = reset ? StFetch : state_q;

      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      alu_op    = 2'b00;
      Illegal   = 1'b0;

      case (out_state)
         StFetch: begin
            IRWrite   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
         end
         StDecode: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            Illegal = ~op_legal;
         end
         StMemAdr, StJalrAdr: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         StMemRead: begin
            AdrSrc = 1'b1;
         end
         StMemWb: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         StMemWrite: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         StExecR: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
         end
         StExecI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
         end
         StAluWb: begin
            RegWrite = 1'b1;
         end
         StJal: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         StLui: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
         end
         StAuipc: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         StBranch: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            PCWrite = taken;
         end
         default: ;
      endcase

      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

   // ALU operation decode. SUB needs op[5] so that I-type with instr[30]
   // set (part of the immediate) still adds.
   always_comb begin
      ALUControl = AluAdd;
      case (alu_op)
         2'b00: ALUControl = AluAdd;
         2'b01: ALUControl = AluSub;
         default: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? AluSub : AluAdd;
               3'b010:  ALUControl = AluSlt;
               3'b011:  ALUControl = AluSltu;
               3'b110:  ALUControl = AluOr;
               3'b111:  ALUControl = AluAnd;
               default: ALUControl = AluAdd;
            endcase
         end
      endcase
   end

   // Immediate format from the opcode alone
   always_comb begin
      case (op)
         OpStore:         ImmSrc = 3'b001;
         OpBranch:        ImmSrc = 3'b010;
         OpJal:           ImmSrc = 3'b011;
         OpLui, OpAuipc:  ImmSrc = 3'b100;
         default:         ImmSrc = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Every cycle's outputs are
// packed into one signature and compared against hand-written expectations.

module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero, lt, ltu;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc, ALUControl;

   int n_tests = 0;
   int n_fail  = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .lt         (lt),
      .ltu        (ltu),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal)
   );

   always #5 clk = ~clk;

   // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
   //  ALUSrcB, ALUControl, Illegal}
   logic [14:0] obs;
   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, Illegal};

   function automatic logic [14:0] sig(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, ill};
   endfunction

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected signatures per state
   function automatic logic [14:0] s_fetch();
      return sig(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
   endfunction
   function automatic logic [14:0] s_reset();
      return sig(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
   endfunction
   function automatic logic [14:0] s_decode(input logic ill);
      return sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, ill);
   endfunction
   function automatic logic [14:0] s_adr();
      return sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
   endfunction
   function automatic logic [14:0] s_aluwb();
      return sig(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
   endfunction

   task automatic run_alu(input string tag, input logic [6:0] o,
                          input logic [2:0] f3, input logic f7,
                          input logic [2:0] exp_ac);
      logic [1:0] sb;
      sb = o[5] ? 2'b00 : 2'b01;
      op = o; funct3 = f3; funct7b5 = f7;
      tick(); check({tag, "_decode"}, {1'b0, obs}, {1'b0, s_decode(0)});
      tick(); check({tag, "_exec"}, {1'b0, obs},
                    {1'b0, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, exp_ac, 0)});
      tick(); check({tag, "_wb"}, {1'b0, obs}, {1'b0, s_aluwb()});
      tick(); check({tag, "_fetch"}, {1'b0, obs}, {1'b0, s_fetch()});
   endtask

   task automatic run_branch(input string tag, input logic [2:0] f3,
                             input logic z, input logic l, input logic lu,
                             input logic tk);
      op = 7'b1100011; funct3 = f3; Zero = z; lt = l; ltu = lu;
      tick(); check({tag, "_decode"}, {1'b0, obs}, {1'b0, s_decode(0)});
      check({tag, "_imm"}, {13'd0, ImmSrc}, 16'd2);
      tick(); check({tag, "_branch"}, {1'b0, obs},
                    {1'b0, sig(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0)});
      tick(); check({tag, "_fetch"}, {1'b0, obs}, {1'b0, s_fetch()});
      Zero = 0; lt = 0; ltu = 0;
   endtask

   initial begin
      reset = 1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1;
      Zero = 0; lt = 0; ltu = 0;

      // Reset for two cycles, then sub
      tick(); check("rst0", {1'b0, obs}, {1'b0, s_reset()});
      tick(); check("rst1", {1'b0, obs}, {1'b0, s_reset()});
      reset = 0; #1;
      check("sub_fetch0", {1'b0, obs}, {1'b0, s_fetch()});
      run_alu("sub", 7'b0110011, 3'b000, 1'b1, 3'b001);

      // ALU decode variants
      run_alu("addi_f7", 7'b0010011, 3'b000, 1'b1, 3'b000);
      run_alu("and", 7'b0110011, 3'b111, 1'b0, 3'b010);
      run_alu("or", 7'b0110011, 3'b110, 1'b0, 3'b011);
      run_alu("slti", 7'b0010011, 3'b010, 1'b0, 3'b101);
      run_alu("sltu", 7'b0110011, 3'b011, 1'b0, 3'b110);
      run_alu("xor_add", 7'b0110011, 3'b100, 1'b1, 3'b000);

      // lw: 5 cycles
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 0;
      tick(); check("lw_decode", {1'b0, obs}, {1'b0, s_decode(0)});
      check("lw_imm", {13'd0, ImmSrc}, 16'd0);
      tick(); check("lw_adr", {1'b0, obs}, {1'b0, s_adr()});
      tick(); check("lw_read", {1'b0, obs},
                    {1'b0, sig(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0)});
      tick(); check("lw_wb", {1'b0, obs},
                    {1'b0, sig(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0)});
      tick(); check("lw_fetch", {1'b0, obs}, {1'b0, s_fetch()});

      // sw: 4 cycles
      op = 7'b0100011;
      tick(); check("sw_decode", {1'b0, obs}, {1'b0, s_decode(0)});
      check("sw_imm", {13'd0, ImmSrc}, 16'd1);
      tick(); check("sw_adr", {1'b0, obs}, {1'b0, s_adr()});
      tick(); check("sw_write", {1'b0, obs},
                    {1'b0, sig(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0)});
      tick(); check("sw_fetch", {1'b0, obs}, {1'b0, s_fetch()});

      // Branches
      run_branch("bge_lt1", 3'b101, 0, 1, 0, 0);
      run_branch("bge_lt0", 3'b101, 0, 0, 0, 1);
      run_branch("bne_z1", 3'b001, 1, 0, 0, 0);
      run_branch("bne_z0", 3'b001, 0, 0, 0, 1);
      run_branch("bgeu_ltu1", 3'b111, 0, 0, 1, 0);
      run_branch("bgeu_ltu0", 3'b111, 0, 0, 0, 1);
      run_branch("f3_010", 3'b010, 1, 1, 1, 0);
      run_branch("f3_010b", 3'b010, 0, 0, 0, 0);
      run_branch("beq_z1", 3'b000, 1, 0, 0, 1);
      run_branch("bltu_ltu1", 3'b110, 0, 0, 1, 1);

      // jalr
      op = 7'b1100111; funct3 = 3'b000;
      tick(); check("jalr_decode", {1'b0, obs}, {1'b0, s_decode(0)});
      tick(); check("jalr_adr", {1'b0, obs}, {1'b0, s_adr()});
      tick(); check("jalr_jal", {1'b0, obs},
                    {1'b0, sig(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0)});
      tick(); check("jalr_wb", {1'b0, obs}, {1'b0, s_aluwb()});
      tick(); check("jalr_fetch", {1'b0, obs}, {1'b0, s_fetch()});

      // jal
      op = 7'b1101111;
      tick(); check("jal_decode", {1'b0, obs}, {1'b0, s_decode(0)});
      check("jal_imm", {13'd0, ImmSrc}, 16'd3);
      tick(); check("jal_jal", {1'b0, obs},
                    {1'b0, sig(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0)});
      tick(); check("jal_wb", {1'b0, obs}, {1'b0, s_aluwb()});
      tick(); check("jal_fetch", {1'b0, obs}, {1'b0, s_fetch()});

      // lui
      op = 7'b0110111;
      tick(); check("lui_decode", {1'b0, obs}, {1'b0, s_decode(0)});
      tick(); check("lui_state", {1'b0, obs},
                    {1'b0, sig(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 0)});
      check("lui_imm", {13'd0, ImmSrc}, 16'd4);
      tick(); check("lui_wb", {1'b0, obs}, {1'b0, s_aluwb()});
      tick(); check("lui_fetch", {1'b0, obs}, {1'b0, s_fetch()});

      // auipc
      op = 7'b0010111;
      tick(); check("auipc_decode", {1'b0, obs}, {1'b0, s_decode(0)});
      tick(); check("auipc_state", {1'b0, obs},
                    {1'b0, sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0)});
      check("auipc_imm", {13'd0, ImmSrc}, 16'd4);
      tick(); check("auipc_wb", {1'b0, obs}, {1'b0, s_aluwb()});
      tick(); check("auipc_fetch", {1'b0, obs}, {1'b0, s_fetch()});

      // Illegal opcode
      op = 7'b1111111;
      tick(); check("ill_decode", {1'b0, obs}, {1'b0, s_decode(1)});
      tick(); check("ill_fetch", {1'b0, obs}, {1'b0, s_fetch()});

      // Reset asserted mid-MEMWRITE
      op = 7'b0100011; funct3 = 3'b010;
      tick(); check("rsw_decode", {1'b0, obs}, {1'b0, s_decode(0)});
      tick(); check("rsw_adr", {1'b0, obs}, {1'b0, s_adr()});
      tick(); check("rsw_write", {1'b0, obs},
                    {1'b0, sig(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0)});
      reset = 1; #1;
      check("rsw_write_rst", {1'b0, obs}, {1'b0, s_reset()});
      tick(); check("rsw_fetch_rst", {1'b0, obs}, {1'b0, s_reset()});
      reset = 0; #1;
      check("rsw_fetch", {1'b0, obs}, {1'b0, s_fetch()});
      tick(); check("rsw_decode2", {1'b0, obs}, {1'b0, s_decode(0)});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
